// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Bus bundle between the fetch stage and its surroundings:
//               EX/MEM redirect, instruction-memory load port, optional
//               stall request, and the PC / IF-ID register outputs.
//               Optional feature macro: FETCH_STALL_EN (adds stall).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
  parameter int ADDR_W = 7
);

  // Redirect from EX/MEM
  logic              ex_mem_pc_src;
  logic [31:0]       ex_mem_npc;

  // Instruction memory load port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

`ifdef FETCH_STALL_EN
  // Hold request from the hazard unit
  logic              stall;
`endif

  // Fetch stage state towards decode
  logic [31:0]       pc;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_npc;

`ifdef FETCH_STALL_EN
  modport master (
    output ex_mem_pc_src, ex_mem_npc,
    output imem_we, imem_waddr, imem_wdata,
    output stall,
    input  pc, if_id_instr, if_id_npc
  );

  modport slave (
    input  ex_mem_pc_src, ex_mem_npc,
    input  imem_we, imem_waddr, imem_wdata,
    input  stall,
    output pc, if_id_instr, if_id_npc
  );
`else
  modport master (
    output ex_mem_pc_src, ex_mem_npc,
    output imem_we, imem_waddr, imem_wdata,
    input  pc, if_id_instr, if_id_npc
  );

  modport slave (
    input  ex_mem_pc_src, ex_mem_npc,
    input  imem_we, imem_waddr, imem_wdata,
    output pc, if_id_instr, if_id_npc
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, reads a word-addressed
//               instruction memory combinationally, computes PC+1 and loads
//               the IF/ID pipeline register. EX/MEM can redirect the PC.
//               Optional feature macro: FETCH_STALL_EN (stall/hold support).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int ADDR_W = 7
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fetch_stage_if.slave  bus
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  // Instruction storage; deliberately not reset so it maps onto plain RAM
  logic [31:0] mem [0:DEPTH-1];

  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;

  logic [31:0] npc;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic        hold;

  // Stall request only exists in the stall-capable build
`ifdef FETCH_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  // Sequential PC, redirect select and aliased memory read
  always_comb begin
    npc     = pc + 32'd1;
    next_pc = bus.ex_mem_pc_src ? bus.ex_mem_npc : npc;
    instr   = mem[pc[ADDR_W-1:0]];
  end

  // Program-load write port; independent of reset and stall
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // PC register: a redirect still moves the PC while IF/ID is held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= 32'd0;
    end else if (bus.ex_mem_pc_src || !hold) begin
      pc <= next_pc;
    end
  end

  // IF/ID register always captures the sequential npc, never the target
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_instr <= NOP;
      if_id_npc   <= 32'd0;
    end else if (!hold) begin
      if_id_instr <= instr;
      if_id_npc   <= npc;
    end
  end

  assign bus.pc          = pc;
  assign bus.if_id_instr = if_id_instr;
  assign bus.if_id_npc   = if_id_npc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a scoreboard queue of
//               expected PC / IF-ID values. Stall steps are built only with
//               FETCH_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int ADDR_W = 7;
`ifdef FETCH_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  exp_t        sb[$];
  logic [31:0] m_mem [0:(1<<ADDR_W)-1];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;

  fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then check it after the edge
  task automatic step(input logic rn, input logic src, input logic [31:0] tgt,
                      input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [31:0] wd, input logic st);
    exp_t e;
    exp_t got;
    logic hold;
    rst_n             = rn;
    bus.ex_mem_pc_src = src;
    bus.ex_mem_npc    = tgt;
    bus.imem_we       = we;
    bus.imem_waddr    = wa;
    bus.imem_wdata    = wd;
`ifdef FETCH_STALL_EN
    bus.stall         = st;
`endif
    hold = st & STALL_EN;
    if (!rn) begin
      e.pc = 32'd0; e.instr = 32'd0; e.npc = 32'd0;
    end else begin
      e.pc    = src ? tgt : (hold ? m_pc : m_pc + 32'd1);
      e.instr = hold ? m_instr : m_mem[m_pc[ADDR_W-1:0]];
      e.npc   = hold ? m_npc : m_pc + 32'd1;
    end
    m_pc = e.pc; m_instr = e.instr; m_npc = e.npc;
    if (we) m_mem[wa] = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("pc", bus.pc, got.pc);
    chk("if_id_instr", bus.if_id_instr, got.instr);
    chk("if_id_npc", bus.if_id_npc, got.npc);
  endtask

  task automatic run(input logic src, input logic [31:0] tgt);
    step(1'b1, src, tgt, 1'b0, '0, 32'd0, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_pc = 0; m_instr = 0; m_npc = 0;
    rst_n = 1'b0;
    bus.ex_mem_pc_src = 1'b0;
    bus.ex_mem_npc    = 32'd0;
    bus.imem_we       = 1'b0;
    bus.imem_waddr    = '0;
    bus.imem_wdata    = 32'd0;
`ifdef FETCH_STALL_EN
    bus.stall         = 1'b0;
`endif

    // Reset held while the program is loaded; redirect/stall must not matter
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      step(1'b0, i[0], 32'h55, 1'b1, i[ADDR_W-1:0], 32'hA000_0000 + i, i[1]);
    end
    chk("reset_pc_const", bus.pc, 32'd0);
    chk("reset_instr_const", bus.if_id_instr, 32'd0);

    // Sequential fetch from address 0
    run(1'b0, 32'd0);
    chk("seq0_instr_const", bus.if_id_instr, 32'hA000_0000);
    chk("seq0_npc_const", bus.if_id_npc, 32'd1);
    run(1'b0, 32'd0);
    run(1'b0, 32'd0);
    chk("seq2_instr_const", bus.if_id_instr, 32'hA000_0002);
    chk("seq2_pc_const", bus.pc, 32'd3);
    run(1'b0, 32'd0);
    chk("seq3_npc_const", bus.if_id_npc, 32'd4);

    // Redirect at pc=4 to 0x10: IF/ID keeps sequential npc
    run(1'b1, 32'h10);
    chk("redir_pc_const", bus.pc, 32'h10);
    chk("redir_npc_const", bus.if_id_npc, 32'd5);
    run(1'b0, 32'd0);
    chk("redir_instr_const", bus.if_id_instr, 32'hA000_0010);
    chk("redir_npc2_const", bus.if_id_npc, 32'h11);

    // Aliasing: 0x80 reads word 0
    run(1'b1, 32'h80);
    run(1'b0, 32'd0);
    chk("alias_instr_const", bus.if_id_instr, 32'hA000_0000);
    chk("alias_npc_const", bus.if_id_npc, 32'h81);

    // Wrap: 0xFFFFFFFF + 1 = 0
    run(1'b1, 32'hFFFF_FFFF);
    run(1'b0, 32'd0);
    chk("wrap_pc_const", bus.pc, 32'd0);
    chk("wrap_npc_const", bus.if_id_npc, 32'd0);
    chk("wrap_instr_const", bus.if_id_instr, 32'hA000_007F);

    // Write/read collision at pc=5
    run(1'b1, 32'd5);
    step(1'b1, 1'b0, 32'd0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0);
    chk("coll_old_const", bus.if_id_instr, 32'hA000_0005);
    run(1'b1, 32'd5);
    run(1'b0, 32'd0);
    chk("coll_new_const", bus.if_id_instr, 32'hDEAD_BEEF);

    // Mixed redirects and writes back-to-back
    step(1'b1, 1'b1, 32'h40, 1'b1, 7'h40, 32'h1234_5678, 1'b0);
    run(1'b0, 32'd0);
    chk("wr_redir_instr_const", bus.if_id_instr, 32'h1234_5678);
    run(1'b0, 32'd0);

`ifdef FETCH_STALL_EN
    // Stall at pc=4 for three edges
    run(1'b1, 32'd4);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b1);
      chk("stall_pc_const", bus.pc, 32'd4);
    end
    // Stall with redirect: PC moves, IF/ID holds; write still lands
    step(1'b1, 1'b1, 32'h20, 1'b1, 7'h21, 32'hCAFE_0021, 1'b1);
    chk("stall_redir_pc_const", bus.pc, 32'h20);
    run(1'b0, 32'd0);
    chk("post_stall_instr_const", bus.if_id_instr, 32'hA000_0020);
    run(1'b0, 32'd0);
    chk("stall_write_const", bus.if_id_instr, 32'hCAFE_0021);
`endif

    // Mid-run reset, then fetch restarts at word 0
    step(1'b0, 1'b1, 32'h33, 1'b0, '0, 32'd0, 1'b0);
    run(1'b0, 32'd0);
    chk("rerun_pc_const", bus.pc, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU. It holds the program counter, reads the instruction word from a word-addressed instruction memory, computes the sequential next PC (PC+1), and registers instruction and next-PC into the IF/ID pipeline register for the decode stage. The EX/MEM stage redirects the PC on a taken branch or jump through a select/target pair.

## Interface
- ADDR_W, default 7: instruction memory address width. Depth is 2^ADDR_W words of 32 bits; the default is 128 words.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
- ex_mem_pc_src  in  1  when 1, the PC redirects to ex_mem_npc.
- ex_mem_npc  in  32  branch/jump target, word address.
- imem_we  in  1  instruction-memory write enable, used for program load.
- imem_waddr  in  ADDR_W  write address.
- imem_wdata  in  32  write data.
- stall  in  1  hold request. Present only with FETCH_STALL_EN.
- pc  out  32  current PC, a registered word address.
- if_id_instr  out  32  IF/ID instruction register.
- if_id_npc  out  32  IF/ID next-PC register, equal to the fetched PC+1.

## Operation
- npc = pc + 1, 32-bit unsigned. It wraps from 0xFFFFFFFF to 0.
- next_pc = ex_mem_pc_src ? ex_mem_npc : npc.
- Instruction read is combinational: instr = mem[pc[ADDR_W-1:0]].
  - Upper PC bits are ignored, so addresses alias modulo 2^ADDR_W.
- Every rising clk edge with rst_n=1 (and no stall):
  - pc <= next_pc
  - if_id_instr <= instr
  - if_id_npc <= npc
- The IF/ID register always captures the sequential npc, even on a redirect cycle.
- No flush is performed. Squashing a wrong-path instruction is the hazard unit's job.
- Memory write is synchronous. On a rising edge with imem_we=1, mem[imem_waddr] <= imem_wdata.
- A fetch from the address being written in the same cycle returns the old contents. The new word is visible from the next cycle.
- Memory contents are not cleared by reset. They are undefined (X) until written.
- Writes are accepted during reset.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - pc = 0
  - if_id_instr = 0x00000000 (NOP)
  - if_id_npc = 0
- Reset overrides redirect and stall.
- Reset is sampled only on clk edges. Deasserting it mid-cycle has no effect until the next edge.
- Latency:
  - The instruction at address A appears on if_id_instr one edge after pc=A.
  - On the same edge, if_id_npc = A+1.
- Redirect latency is one edge: ex_mem_pc_src sampled high at edge k gives pc = ex_mem_npc after edge k.
- Throughput is one instruction per clock.
- First edge after reset release: if_id_instr = mem[0], if_id_npc = 1, pc = 1.

## Configuration
- FETCH_STALL_EN defined:
  - The `stall` port exists.
  - When stall=1 at an edge, pc, if_id_instr and if_id_npc hold their values.
  - If ex_mem_pc_src=1 together with stall=1, the redirect wins for pc (pc <= ex_mem_npc) and IF/ID still holds.
  - Memory writes are unaffected by stall.
- FETCH_STALL_EN undefined:
  - No `stall` port.
  - The stage advances every non-reset cycle.

## Test plan
- Reset: hold rst_n=0 for 2 edges -> pc=0, if_id_instr=0, if_id_npc=0.
- Sequential fetch: load mem[0..3] with 0xA0000000, 0xA0000001, 0xA0000002, 0xA0000003 and release reset -> on successive edges if_id_instr = A0000000…A0000003, if_id_npc = 1,2,3,4, pc = 1..4.
- Redirect: at pc=2, assert ex_mem_pc_src=1 with ex_mem_npc=0x10 for one cycle -> that edge gives if_id_npc=3 and pc=0x10; the next edge gives if_id_instr=mem[0x10] and if_id_npc=0x11.
- Aliasing and wrap: redirect to 0x80 with ADDR_W=7 -> instruction fetched is mem[0]. Redirect to 0xFFFFFFFF -> if_id_npc=0 and pc=0.
- Write/read collision: at pc=5, write 0xDEADBEEF to address 5 -> if_id_instr gets the old mem[5]. A later redirect to 5 fetches 0xDEADBEEF.
- Stall (FETCH_STALL_EN): assert stall for 3 edges at pc=4 -> pc and IF/ID stay constant. Stall with redirect to 0x20 -> pc=0x20 and IF/ID unchanged.
